// File: rtl/ras_return_checker_pkg.sv
// ras_return_checker_pkg: shared core configuration type, counter width default and prediction record
package ras_return_checker_pkg;

    // Minimal core configuration record; only the datapath width is consumed here.
    typedef struct packed {
        int XLEN;
    } cvw_t;

    localparam int   DEFAULT_XLEN        = 32;
    localparam cvw_t CVW_DEFAULT         = '{XLEN: DEFAULT_XLEN};
    localparam int   COUNT_WIDTH_DEFAULT = 32;

    // One RAS prediction as it travels down the pipeline.
    typedef struct packed {
        logic                    Valid;
        logic [DEFAULT_XLEN-1:0] PC;
    } ras_pred_t;

endpackage

// File: rtl/ras_return_checker_if.sv
// ras_return_checker_if: pipeline control, Fetch/Execute inputs and checker results
// master drives stalls/flushes, BPReturnF, RASPCF, ReturnE, IEUAdrE and observes the results;
// slave (the checker) drives RASPredValidE, RASPredPCE, RASTargetWrongE and, with
// RAS_PERF_COUNTERS_EN defined, RASHitCount/RASMissCount.
interface ras_return_checker_if
    import ras_return_checker_pkg::*;
#(
    parameter cvw_t P          = CVW_DEFAULT,
    parameter int   CountWidth = COUNT_WIDTH_DEFAULT
);
    logic               StallD, StallE, StallM;
    logic               FlushD, FlushE, FlushM;
    logic               BPReturnF;
    logic [P.XLEN-1:0]  RASPCF;
    logic               ReturnE;
    logic [P.XLEN-1:0]  IEUAdrE;
    logic               RASPredValidE;
    logic [P.XLEN-1:0]  RASPredPCE;
    logic               RASTargetWrongE;
`ifdef RAS_PERF_COUNTERS_EN
    logic [CountWidth-1:0] RASHitCount;
    logic [CountWidth-1:0] RASMissCount;
`endif

    if (CountWidth < 1) begin : g_bad_width
        $error("CountWidth must be at least 1");
    end

    modport master (
        output StallD, StallE, StallM, FlushD, FlushE, FlushM,
        output BPReturnF, RASPCF, ReturnE, IEUAdrE,
`ifdef RAS_PERF_COUNTERS_EN
        input  RASHitCount, RASMissCount,
`endif
        input  RASPredValidE, RASPredPCE, RASTargetWrongE
    );

    modport slave (
        input  StallD, StallE, StallM, FlushD, FlushE, FlushM,
        input  BPReturnF, RASPCF, ReturnE, IEUAdrE,
`ifdef RAS_PERF_COUNTERS_EN
        output RASHitCount, RASMissCount,
`endif
        output RASPredValidE, RASPredPCE, RASTargetWrongE
    );
endinterface

// File: rtl/flopenrc.sv
// flopenrc: enabled register with synchronous clear and synchronous active-high reset
// Ports: clk, reset, clear (zero on enabled edge), en (load enable), d, q.
module flopenrc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // clear only takes effect when enabled, so a stalled stage ignores its flush
    always_ff @(posedge clk)
        if (reset)   q <= '0;
        else if (en) q <= clear ? '0 : d;
endmodule

// File: rtl/ras_return_checker_sat_counter.sv
// sat_counter: up counter that sticks at all-ones instead of wrapping
// Ports: clk, reset (sync, active-high), Inc (count this cycle), Count (current value).
module sat_counter #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Inc,
    output logic [Width-1:0] Count
);
    always_ff @(posedge clk)
        if (reset)                Count <= '0;
        else if (Inc & ~&Count)   Count <= Count + 1'b1;
endmodule

// File: rtl/ras_return_checker.sv
// ras_return_checker: carries RAS return predictions from Fetch to Execute and flags wrong targets
// Ports: clk, reset (sync, active-high), bus (ras_return_checker_if.slave).
// Optional feature macro RAS_PERF_COUNTERS_EN adds saturating hit/miss counters on the bus.
module ras_return_checker
    import ras_return_checker_pkg::*;
#(
    parameter cvw_t P          = CVW_DEFAULT,
    parameter int   CountWidth = COUNT_WIDTH_DEFAULT
) (
    input logic                 clk,
    input logic                 reset,
    ras_return_checker_if.slave bus
);
    typedef struct packed {
        logic              Valid;
        logic [P.XLEN-1:0] PC;
    } pred_t;

    pred_t pred_f, pred_d, pred_e;
    logic  target_eq_e;

    if (CountWidth < 1) begin : g_bad_width
        $error("CountWidth must be at least 1");
    end

    assign pred_f = '{Valid: bus.BPReturnF, PC: bus.RASPCF};

    flopenrc #(.WIDTH($bits(pred_t))) d_reg (
        .clk(clk), .reset(reset), .clear(bus.FlushD), .en(~bus.StallD), .d(pred_f), .q(pred_d)
    );

    flopenrc #(.WIDTH($bits(pred_t))) e_reg (
        .clk(clk), .reset(reset), .clear(bus.FlushE), .en(~bus.StallE), .d(pred_d), .q(pred_e)
    );

    assign target_eq_e         = pred_e.PC == bus.IEUAdrE;
    assign bus.RASPredValidE   = pred_e.Valid;
    assign bus.RASPredPCE      = pred_e.PC;
    // a valid prediction on a non-return is a class error reported elsewhere, so gate on ReturnE
    assign bus.RASTargetWrongE = pred_e.Valid & bus.ReturnE & ~target_eq_e;

`ifdef RAS_PERF_COUNTERS_EN
    logic retire_e, hit_e;
    assign retire_e = bus.ReturnE & ~bus.StallM & ~bus.FlushM;
    assign hit_e    = pred_e.Valid & target_eq_e;

    sat_counter #(.Width(CountWidth)) hit_cnt (
        .clk(clk), .reset(reset), .Inc(retire_e & hit_e), .Count(bus.RASHitCount)
    );

    // an unpredicted return counts as a miss just like a wrong target
    sat_counter #(.Width(CountWidth)) miss_cnt (
        .clk(clk), .reset(reset), .Inc(retire_e & ~hit_e), .Count(bus.RASMissCount)
    );
`endif
endmodule

// File: tb/tb_ras_return_checker.sv
// tb_ras_return_checker: vector table, directed corner sequences and random stimulus against a reference model
module tb_ras_return_checker;
    import ras_return_checker_pkg::*;

`ifdef RAS_PERF_COUNTERS_EN
    localparam int CW = 4;
`else
    localparam int CW = 32;
`endif
    localparam logic [31:0] A    = 32'h8000_0104;
    localparam logic [31:0] B    = 32'h8000_0200;
    localparam longint      CMAX = (longint'(1) << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ras_return_checker_if #(.P(CVW_DEFAULT), .CountWidth(CW)) bus ();
    ras_return_checker #(.P(CVW_DEFAULT), .CountWidth(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: D and E slots plus plain integer counters
    ras_pred_t m_d, m_e;
    longint    m_hit, m_miss;

    typedef struct {
        logic        sd, se, sm, fd, fe, fm, bp;
        logic [31:0] rpc;
        logic        re;
        logic [31:0] adr;
        logic        ev;
        logic [31:0] epc;
        logic        ew;
        int          eh, em;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic sd, se, sm, fd, fe, fm, bp, input logic [31:0] rpc,
                          input logic re, input logic [31:0] adr);
        bus.StallD = sd; bus.StallE = se; bus.StallM = sm;
        bus.FlushD = fd; bus.FlushE = fe; bus.FlushM = fm;
        bus.BPReturnF = bp; bus.RASPCF = rpc; bus.ReturnE = re; bus.IEUAdrE = adr;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 64'(bus.RASPredValidE), 64'(m_e.Valid));
        chk({tag, ".pc"}, 64'(bus.RASPredPCE), 64'(m_e.PC));
        chk({tag, ".wrong"}, 64'(bus.RASTargetWrongE),
            64'(m_e.Valid && bus.ReturnE && m_e.PC != bus.IEUAdrE));
`ifdef RAS_PERF_COUNTERS_EN
        chk({tag, ".hit"}, 64'(bus.RASHitCount), 64'(m_hit));
        chk({tag, ".miss"}, 64'(bus.RASMissCount), 64'(m_miss));
`endif
    endtask

    // advance one clock; the model applies the rules to the inputs held across the edge
    task automatic tick();
        logic retire, hit;
        @(posedge clk);
        if (reset) begin
            m_d = '0; m_e = '0; m_hit = 0; m_miss = 0;
        end else begin
            retire = bus.ReturnE && !bus.StallM && !bus.FlushM;
            hit    = retire && m_e.Valid && m_e.PC == bus.IEUAdrE;
            if (hit && m_hit < CMAX) m_hit++;
            if (retire && !hit && m_miss < CMAX) m_miss++;
            if (!bus.StallE) m_e = bus.FlushE ? '0 : m_d;
            if (!bus.StallD) m_d = bus.FlushD ? '0 : '{Valid: bus.BPReturnF, PC: bus.RASPCF};
        end
        @(negedge clk);
    endtask

    task automatic step(input string tag);
        #1 check_model(tag);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vec_t tbl[9];
        // {sd,se,sm,fd,fe,fm,bp,rpc,re,adr, exp valid,pc,wrong,hit,miss}
        tbl[0] = '{0,0,0,0,0,0,1,A,0,0,     0,0,0,0,0};
        tbl[1] = '{0,0,0,0,0,0,0,0,0,0,     0,0,0,0,0};
        tbl[2] = '{0,0,0,0,0,0,0,0,1,A,     1,A,0,0,0};
        tbl[3] = '{0,0,0,0,0,0,1,A,0,0,     0,0,0,1,0};
        tbl[4] = '{0,0,0,0,0,0,0,0,0,0,     0,0,0,1,0};
        tbl[5] = '{0,0,0,0,0,0,0,0,1,B,     1,A,1,1,0};
        tbl[6] = '{0,0,0,0,0,0,1,32'h1234,0,0, 0,0,0,1,1};
        tbl[7] = '{0,0,0,0,1,0,0,0,0,0,     0,0,0,1,1};
        tbl[8] = '{0,0,0,0,0,0,0,0,1,32'hdead, 0,0,0,1,1};

        m_d = '0; m_e = '0; m_hit = 0; m_miss = 0;
        @(negedge clk);
        do_reset();
        #1 chk("reset.valid", 64'(bus.RASPredValidE), 0);
        chk("reset.pc", 64'(bus.RASPredPCE), 0);
        chk("reset.wrong", 64'(bus.RASTargetWrongE), 0);

        for (int i = 0; i < 9; i++) begin
            set_in(tbl[i].sd, tbl[i].se, tbl[i].sm, tbl[i].fd, tbl[i].fe, tbl[i].fm,
                   tbl[i].bp, tbl[i].rpc, tbl[i].re, tbl[i].adr);
            #1;
            chk($sformatf("vec%0d.valid", i), 64'(bus.RASPredValidE), 64'(tbl[i].ev));
            chk($sformatf("vec%0d.pc", i), 64'(bus.RASPredPCE), 64'(tbl[i].epc));
            chk($sformatf("vec%0d.wrong", i), 64'(bus.RASTargetWrongE), 64'(tbl[i].ew));
`ifdef RAS_PERF_COUNTERS_EN
            chk($sformatf("vec%0d.hit", i), 64'(bus.RASHitCount), 64'(tbl[i].eh));
            chk($sformatf("vec%0d.miss", i), 64'(bus.RASMissCount), 64'(tbl[i].em));
`endif
            tick();
        end
`ifdef RAS_PERF_COUNTERS_EN
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("unpred.miss", 64'(bus.RASMissCount), 2);
`endif

        // stall hold: Fetch keeps offering the prediction while D is stalled
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 1, A, 0, 0);
            #1 chk($sformatf("stall%0d.pc", i), 64'(bus.RASPredPCE), 0);
            step("stall");
        end
        set_in(0, 0, 0, 0, 0, 0, 1, A, 0, 0);
        step("stall.load");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("stall.e_empty", 64'(bus.RASPredPCE), 0);
        step("stall.d");
        #1 chk("stall.pc_arrive", 64'(bus.RASPredPCE), 64'(A));
        chk("stall.valid_arrive", 64'(bus.RASPredValidE), 1);
        step("stall.e");

        // FlushD and FlushE together empty both stages
        set_in(0, 0, 0, 0, 0, 0, 1, B, 0, 0);
        step("ff.fill");
        set_in(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        step("ff.flush");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, A);
        #1 chk("ff.valid_e", 64'(bus.RASPredValidE), 0);
        step("ff.e");
        #1 chk("ff.valid_d", 64'(bus.RASPredValidE), 0);

        // reset mid-stream wins over stalls and flushes
        set_in(0, 0, 0, 0, 0, 0, 1, A, 0, 0);
        step("mid.fill0");
        step("mid.fill1");
        set_in(1, 1, 1, 1, 0, 0, 1, A, 1, B);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 1, B);
        #1 chk("mid.valid", 64'(bus.RASPredValidE), 0);
        chk("mid.pc", 64'(bus.RASPredPCE), 0);
        check_model("mid");

`ifdef RAS_PERF_COUNTERS_EN
        // saturation: a continuous stream of hits overruns the narrow counter
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, A, 1, A);
        for (int i = 0; i < int'(CMAX) + 6; i++) step("sat");
        #1 chk("sat.hit_full", 64'(bus.RASHitCount), 64'(CMAX));
        tick();
        #1 chk("sat.hit_stays", 64'(bus.RASHitCount), 64'(CMAX));
        do_reset();
        #1 chk("sat.reset_hit", 64'(bus.RASHitCount), 0);
        chk("sat.reset_miss", 64'(bus.RASMissCount), 0);
        chk("sat.reset_valid", 64'(bus.RASPredValidE), 0);
`endif

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(63) == 0);
            set_in($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                   $urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
                   1'($urandom_range(1)), $urandom_range(1) ? A : B,
                   1'($urandom_range(1)), $urandom_range(1) ? A : B);
            step($sformatf("rnd%0d", i));
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ras_return_checker.md
# ras_return_checker

Execute-stage checker for return-address-stack predictions. It captures the RAS top-of-stack target when Fetch predicts a return, and carries that target and a valid bit down the Decode and Execute pipeline registers, honouring stalls and flushes. In Execute it compares the carried target with the resolved return target and raises a target-mispredict flag for the branch-predictor repair logic. Optional saturating hit/miss counters feed the performance-counter CSRs.

## Interface
Parameters:
- P, none (cvw_t), core configuration; datapath width is P.XLEN
- CountWidth, 32, width of each performance counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- StallD, StallE, StallM  in  1 each  pipeline stage stalls
- FlushD, FlushE, FlushM  in  1 each  pipeline stage flushes
- BPReturnF  in  1  Fetch predicted the instruction as a return
- RASPCF  in  P.XLEN  RAS top-of-stack target in Fetch
- ReturnE  in  1  decoded instruction class in Execute is a return
- IEUAdrE  in  P.XLEN  resolved jump target in Execute
- RASPredValidE  out  1  Execute instruction carries a RAS prediction
- RASPredPCE  out  P.XLEN  carried predicted target in Execute
- RASTargetWrongE  out  1  predicted return with wrong target
- RASHitCount  out  CountWidth  correct return predictions (only with macro)
- RASMissCount  out  CountWidth  wrong or missing return predictions (only with macro)

## Operation
- D register (ValidD, PredPCD): loads {BPReturnF, RASPCF} when ~StallD. If FlushD & ~StallD, ValidD is 0 and PredPCD is 0. When StallD is high, the register holds even if FlushD is high.
- E register (ValidE, PredPCE): loads {ValidD, PredPCD} when ~StallE. Uses the same flush rule with FlushE.
- RASPredValidE = ValidE. RASPredPCE = PredPCE.
- RASTargetWrongE = ValidE & ReturnE & (PredPCE != IEUAdrE). The comparison covers the full XLEN width.
- ValidE & ~ReturnE is a class error. The external class-wrong logic reports it, and this block does not flag it.
- Retire event fires when ReturnE & ~StallM & ~FlushM.
  - Hit: retire event & ValidE & target equal. RASHitCount increments by 1.
  - Miss: retire event & (~ValidE | target unequal). RASMissCount increments by 1.
- Both counters saturate at all-ones and never wrap.
- At most one counter increments per cycle.

## Timing
- Reset value of every output and every register is 0.
- With no stalls, a prediction made in cycle n appears on RASPredPCE and RASPredValidE in cycle n+2.
- RASTargetWrongE is combinational from the E register and the Execute inputs. It has zero added latency.
- A counter increments on the clock edge that ends the retire-event cycle, so the new value is visible in the next cycle.
- A stalled E stage with ~StallM holding a return can produce several retire-event cycles. This is acceptable because the pipeline guarantees that StallM is high while E is stalled.
- FlushD and FlushE in the same cycle clear both registers.
- If reset is asserted mid-stream, all registers return to 0 on the next edge, regardless of stalls or flushes.

## Configuration
- RAS_PERF_COUNTERS_EN
  - Defined: the two counters and the RASHitCount and RASMissCount ports exist.
  - Undefined: the counters and both ports are removed. The checking path is unchanged.

## Structure
- The shared package holds:
  - the default for CountWidth;
  - a typedef ras_pred_t, a packed struct {logic Valid; logic [XLEN-1:0] PC;}. It is parameterised through P.XLEN in the cvw package.
- The D and E stages are built from two instances of the existing flopenrc register: enable = ~Stall, clear = Flush.
- The saturating counter is one natural sub-module, sat_counter (parameter Width; ports clk, reset, Inc, Count). It is instanced twice.

## Test plan
- Basic hit:
  - Stimulus: BPReturnF=1, RASPCF=0x8000_0104 in cycle 0; two cycles later ReturnE=1, IEUAdrE=0x8000_0104.
  - Required: RASPredValidE=1, RASTargetWrongE=0; RASHitCount goes 0→1 with the macro defined.
- Wrong target:
  - Stimulus: same as basic hit, but IEUAdrE=0x8000_0200.
  - Required: RASTargetWrongE=1 in that cycle; RASMissCount=1.
- Stall hold:
  - Stimulus: StallD=1 for 3 cycles after the prediction.
  - Required: RASPredPCE stays 0 for 3 extra cycles, then 0x8000_0104 arrives intact.
- Flush:
  - Stimulus: FlushE=1 while the prediction is in D.
  - Required: ValidE=0 next cycle, and no RASTargetWrongE even when ReturnE=1 and the targets mismatch.
- Unpredicted return:
  - Stimulus: ReturnE=1 with ValidE=0.
  - Required: RASTargetWrongE=0; RASMissCount increments by 1.
- Saturation and reset:
  - Stimulus: preload RASHitCount to all-ones via a forced stream of hits, then drive one more hit.
  - Required: the count stays at 0xFFFF_FFFF. A subsequent reset returns all outputs to 0.
